// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master: FSM states, command codes
// and the quarter-bit period helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WRITE,
    READ,
    STOP,
    HOLD
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  // Each bit or bus condition is split into four equal quarters.
  function automatic int qtr_cycles(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit timebase: counts QTR clk cycles while enabled and emits a
// one-cycle tick at the end of each quarter; hold freezes the count.
module i2c_qtr_tick #(
  parameter int QTR = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic hold,
  output logic tick
);

  localparam int W = (QTR > 1) ? $clog2(QTR) : 1;

  logic [W-1:0] cnt;

  assign tick = enable && !hold && (cnt == W'(QTR - 1));

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !enable || tick) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master with START/WRITE/READ/STOP commands on open-drain SCL/SDA.
// Optional slave clock stretching is enabled by defining I2C_MASTER_STRETCH_EN.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       ack_in,
  output logic       cmd_ready,
  output logic       done,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       ack_err,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int QTR = qtr_cycles(CLK_FREQ, I2C_FREQ);

  state_t     state;
  logic [1:0] q;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       ack_bit;
  logic       rep;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_want;
  logic       sda_want;
  logic       tick;
  logic       hold;
  logic       last_q;
  logic       sda_in;

  // Open-drain: a set *_oe pulls the line low, otherwise it floats high.
  assign SCL    = scl_oe ? 1'b0 : 1'bz;
  assign SDA    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = SDA;

`ifdef I2C_MASTER_STRETCH_EN
  // Once we have released SCL, a slave still holding it low stretches the high phase.
  assign hold = busy && (q == 2'd1) && !scl_oe && !SCL;
`else
  assign hold = 1'b0;
`endif

  i2c_qtr_tick #(
    .QTR(QTR)
  ) u_qtr_tick (
    .clk   (clk),
    .reset (reset),
    .enable(busy),
    .hold  (hold),
    .tick  (tick)
  );

  assign last_q = tick && (q == 2'd3) &&
                  (state == START || state == STOP || bit_cnt == 4'd8);

  // Bus levels wanted for the current state/quarter; registered below.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    scl_want = scl_oe;
    sda_want = sda_oe;
    unique case (state)
      IDLE: begin
        scl_want = 1'b0;
        sda_want = 1'b0;
      end
      START: begin
        if (!rep) begin
          scl_want = (q >= 2'd2);
          sda_want = (q != 2'd0);
        end else begin
          scl_want = (q == 2'd0) || (q == 2'd3);
          sda_want = (q >= 2'd2);
        end
      end
      WRITE: begin
        scl_want = (q == 2'd0) || (q == 2'd3);
        sda_want = (bit_cnt == 4'd8) ? 1'b0 : !shreg[7];
      end
      READ: begin
        scl_want = (q == 2'd0) || (q == 2'd3);
        sda_want = (bit_cnt == 4'd8) && !ack_bit;
      end
      STOP: begin
        scl_want = (q == 2'd0);
        sda_want = (q <= 2'd1);
      end
      HOLD: begin
        scl_want = 1'b1;
      end
      default: begin
        scl_want = 1'b0;
        sda_want = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q         <= 2'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      ack_bit   <= 1'b1;
      rep       <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      done   <= 1'b0;
      scl_oe <= scl_want;
      sda_oe <= sda_want;
      if (state == IDLE || state == HOLD) begin
        // Only START is meaningful from IDLE; anything else is dropped silently.
        if (cmd_valid && (state == HOLD || cmd == CMD_START)) begin
          q         <= 2'd0;
          bit_cnt   <= 4'd0;
          busy      <= 1'b1;
          cmd_ready <= 1'b0;
          rep       <= (state == HOLD);
          shreg     <= tx_data;
          ack_bit   <= ack_in;
          unique case (cmd)
            CMD_START: state <= START;
            CMD_WRITE: state <= WRITE;
            CMD_READ:  state <= READ;
            CMD_STOP:  state <= STOP;
            default:   state <= HOLD;
          endcase
        end
      end else if (tick) begin
        q <= q + 2'd1;
        if (q == 2'd2) begin
          if (state == READ && bit_cnt != 4'd8) shreg <= {shreg[6:0], sda_in};
          if (state == WRITE && bit_cnt == 4'd8) ack_err <= sda_in;
        end
        if (q == 2'd3) begin
          bit_cnt <= bit_cnt + 4'd1;
          if (state == WRITE) shreg <= {shreg[6:0], 1'b0};
        end
        if (last_q) begin
          state     <= (state == STOP) ? IDLE : HOLD;
          bit_cnt   <= 4'd0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          done      <= 1'b1;
          if (state == READ) rx_data <= shreg;
        end
      end
    end
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 100_000, SCL frequency in Hz; QTR = CLK_FREQ/(4*I2C_FREQ) clk cycles per quarter-bit (250 at defaults).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd  input  2  00 START, 01 WRITE, 10 READ, 11 STOP.
REQ-007 SHALL have port tx_data  input  8  byte for WRITE, sampled at accept.
REQ-008 SHALL have port ack_in  input  1  master ACK bit for READ (0 ACK, 1 NACK), sampled at accept.
REQ-009 SHALL have port cmd_ready  output  1  command may be accepted.
REQ-010 SHALL have port done  output  1  one-cycle pulse at command completion.
REQ-011 SHALL have port busy  output  1  high while a command executes.
REQ-012 SHALL have port rx_data  output  8  last byte received by READ.
REQ-013 SHALL have port ack_err  output  1  SDA level sampled in the ACK slot of the last WRITE (1 = NACK).
REQ-014 SHALL have port SCL  inout  1  open-drain bus clock.
REQ-015 SHALL have port SDA  inout  1  open-drain bus data.

Function
REQ-016 SHALL drive SCL/SDA only as 0 or Z; released = Z.
REQ-017 SHALL accept a command on the cycle cmd_valid && cmd_ready; cmd_ready high only in IDLE or HOLD.
REQ-018 SHALL use states IDLE, START, WRITE, READ, STOP, HOLD; each bit/condition spans quarters q0..q3 of QTR cycles each.
REQ-019 SHALL perform START from IDLE as: q0 both released, q1 SDA low, q2 SCL low, q3 hold -> HOLD.
REQ-020 SHALL perform START from HOLD (repeated start) as: q0 release SDA, q1 release SCL, q2 SDA low, q3 SCL low -> HOLD.
REQ-021 SHALL perform WRITE as 8 bits MSB first, then ACK slot with SDA released; per bit q0 set SDA (SCL low), q1-q2 SCL released, q3 SCL low; ack_err latched at end of slot q2 -> HOLD.
REQ-022 SHALL perform READ as 8 bits with SDA released, shifting SDA in at end of q2 MSB first, then drive ack_in in the ACK slot; rx_data updated at command end -> HOLD.
REQ-023 SHALL perform STOP as: q0 SDA low, q1 SCL released, q2 SDA released, q3 hold -> IDLE.
REQ-024 SHALL pulse done for exactly one cycle in the final cycle of each command; busy low on that same next cycle.
REQ-025 SHALL ignore WRITE, READ, STOP issued in IDLE (no bus activity, no done); STOP from HOLD is legal.
REQ-026 SHALL hold SCL low and SDA unchanged in HOLD indefinitely until next command.

Reset
REQ-027 SHALL on reset (any state, including mid-byte) set state IDLE, release SCL and SDA, cmd_ready 1, busy 0, done 0, ack_err 0, rx_data 0x00, quarter and bit counters 0.

Configuration
REQ-028 SHALL, with macro I2C_MASTER_STRETCH_EN defined, freeze the quarter counter in q1 while SCL reads 0 after release (slave clock stretching); without it, SCL input SHALL be ignored and timing is fixed.

Structure
REQ-029 SHALL place state enum and cmd code constants (CMD_START, CMD_WRITE, CMD_READ, CMD_STOP) in shared package i2c_pkg.
REQ-030 SHALL implement the quarter-tick counter as sub-module i2c_qtr_tick (enable, hold input, tick output).

Verification (CLK_FREQ 100 MHz, I2C_FREQ 100 kHz, bit = 1000 clk)
REQ-031 START, WRITE 0xA0, slave ACK, STOP -> SDA bits 1010_0000 on SCL rising edges, ack_err 0, three done pulses, bus released at end.
REQ-032 START, WRITE 0x91, READ ack_in=1, slave sends 0x3C -> rx_data 0x3C, SDA high in master ACK slot, READ lasts 9000 clk.
REQ-033 WRITE 0x50 with no slave response (SDA pulled up) -> ack_err 1, state HOLD, cmd_ready 1.
REQ-034 cmd WRITE in IDLE -> no SCL/SDA transition for 2000 clk, no done, cmd_ready stays 1.
REQ-035 reset asserted at bit 4 of WRITE -> next cycle SCL/SDA released, busy 0, rx_data 0x00.
REQ-036 slave holds SCL low 500 clk in bit 0 -> with I2C_MASTER_STRETCH_EN WRITE lasts 9500 clk; without, 9000 clk.
